// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick function for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BURST)
//   rr_pick_t   : result of a round-robin scan {found, idx}
//   rr_next()   : first set request scanning last+1 .. last+n (mod n)
package fifo_arb_pkg;

    // Upper bound on requesters the shared scan function supports
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans downwards so the last hit written is the one closest to last+1,
    // which keeps the loop bound constant for synthesis.
    function automatic rr_pick_t rr_next(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [RR_IDX_W-1:0]   last,
                                         input int                    n);
        rr_pick_t pick;
        int       cand;
        pick.found = 1'b0;
        pick.idx   = '0;
        for (int k = RR_MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                cand = int'(last) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (req[cand[RR_IDX_W-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = RR_IDX_W'(cand);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational rotate-priority encoder: finds the first asserted request
// starting just after 'last' and wrapping around.
//   req   in  N_REQ           request vector
//   last  in  $clog2(N_REQ)   index with lowest priority this scan
//   found out 1               at least one request set
//   idx   out $clog2(N_REQ)   selected requester
module rr_priority_sel
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    rr_pick_t pick_s;

    // Widen to the package scan width, pick, then narrow back
    always_comb begin
        pick_s = rr_next(RR_MAX_REQ'(req), RR_IDX_W'(last), N_REQ);
        found  = pick_s.found;
        idx    = $clog2(N_REQ)'(pick_s.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async-FIFO write port among N_REQ producers. One producer owns
// the port per burst (max MAX_BURST beats), owners rotate round-robin, and
// every beat is gated by the FIFO full flag.
//   wclk, w_rst : write clock, async active-high reset
//   req/req_data: producer requests and packed data (slice i = producer i)
//   full        : FIFO full flag (wclk domain)
//   gnt         : one-hot beat accept, w_en/wdata: FIFO write port
//   owner, busy : current burst owner and BURST-state indicator
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                        wclk,
    input  logic                        w_rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        full,
    output logic [N_REQ-1:0]            gnt,
    output logic                        w_en,
    output logic [DATA_WIDTH-1:0]       wdata,
    output logic [$clog2(N_REQ)-1:0]    owner,
    output logic                        busy
);

    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [N_REQ-1:0] GNT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t       state_r, state_nxt_s;
    logic [OWN_W-1:0] owner_r, owner_nxt_s;
    logic [OWN_W-1:0] last_r, last_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r, cnt_nxt_s;

    logic             beat_s;
    logic             burst_end_s;
    logic [OWN_W-1:0] scan_base_s;
    logic             pick_found_s;
    logic [OWN_W-1:0] pick_idx_s;

    // In BURST the scan starts after the current owner so a burst end rotates
    // with no bubble; in IDLE it starts after the last finished owner.
    always_comb begin
        beat_s      = (state_r == BURST) && req[owner_r] && !full;
        burst_end_s = (state_r == BURST) &&
                      (!req[owner_r] || (beat_s && (beat_cnt_r == CNT_W'(MAX_BURST - 1))));
        if (state_r == BURST) begin
            scan_base_s = owner_r;
        end else begin
            scan_base_s = last_r;
        end
    end

    rr_priority_sel #(
        .N_REQ (N_REQ)
    ) u_rr_sel (
        .req   (req),
        .last  (scan_base_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state: arbitration, burst rotation and beat counting
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = BURST;
                    owner_nxt_s = pick_idx_s;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (burst_end_s) begin
                    last_nxt_s = owner_r;
                    cnt_nxt_s  = '0;
                    if (pick_found_s) begin
                        state_nxt_s = BURST;
                        owner_nxt_s = pick_idx_s;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (beat_s) begin
                    cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                end else begin
                    // full stall: owner keeps the grant, count holds
                    cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, owner, rotation pointer and beat counter
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            last_r     <= OWN_W'(N_REQ - 1);
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            last_r     <= last_nxt_s;
            beat_cnt_r <= cnt_nxt_s;
        end
    end

    // Write port is combinational so a full flag or reset blocks the beat in the same cycle
    always_comb begin
        w_en  = beat_s;
        if (beat_s) begin
            gnt = GNT_LSB << owner_r;
        end else begin
            gnt = '0;
        end
        wdata = req_data[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
        owner = owner_r;
        busy  = (state_r == BURST);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected
// {owner, data} writes into a queue; a negedge monitor pops on every w_en.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        w_rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic        w_en;
    logic [7:0]  wdata;
    logic [1:0]  owner;
    logic        busy;

    fifo_wr_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (16)
    ) dut (
        .wclk     (wclk),
        .w_rst    (w_rst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .w_en     (w_en),
        .wdata    (wdata),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int         own;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   prod_seq[4];
    int   exp_seq[4];
    int   mon_seq[4];
    int   wr_cnt = 0;
    bit   rand_mode = 1'b0;

    logic       s_wen;
    logic [3:0] s_gnt;
    logic [1:0] s_owner;
    logic       s_busy;
    logic [7:0] s_wdata;

    function automatic logic [7:0] mk_data(input int i, input int s);
        logic [1:0] ii;
        logic [5:0] ss;
        ii = i[1:0];
        ss = s[5:0];
        return {ii, ss} ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = mk_data(i, prod_seq[i]);
    endtask

    task automatic push_exp(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{own: i, data: mk_data(i, exp_seq[i])});
            exp_seq[i]++;
        end
    endtask

    // One clock: sample outputs on negedge, advance producers after the edge
    task automatic tick();
        @(negedge wclk);
        s_wen   = w_en;
        s_gnt   = gnt;
        s_owner = owner;
        s_busy  = busy;
        s_wdata = wdata;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) if (s_gnt[i]) prod_seq[i]++;
        drive_data();
    endtask

    task automatic apply_reset(input logic [3:0] new_req);
        w_rst = 1'b1;
        req   = new_req;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_seq[i] = 0;
            exp_seq[i]  = 0;
            mon_seq[i]  = 0;
        end
        exp_q.delete();
        drive_data();
        tick();
        check("rst_wen",   32'(s_wen),   32'd0);
        check("rst_gnt",   32'(s_gnt),   32'd0);
        check("rst_busy",  32'(s_busy),  32'd0);
        check("rst_owner", 32'(s_owner), 32'd0);
        check("rst_wdata", 32'(s_wdata), 32'(mk_data(0, 0)));
        w_rst  = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic end_test(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor and per-cycle protocol invariants
    always @(negedge wclk) begin
        if (!w_rst) begin
            check("wen_while_full", 32'(w_en & full), 32'd0);
            check("gnt_popcount",   32'($countones(gnt) > 1), 32'd0);
            check("gnt_without_req", 32'(gnt & ~req), 32'd0);
            check("wen_vs_gnt",     32'(w_en), 32'(|gnt));
            if (w_en) begin
                wr_cnt++;
                check("gnt_matches_owner", 32'(gnt), 32'(4'b0001 << owner));
                if (rand_mode) begin
                    check("rand_data_order", 32'(wdata), 32'(mk_data(int'(owner), mon_seq[owner])));
                    mon_seq[owner]++;
                end else if (exp_q.size() == 0) begin
                    check("write_with_empty_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_owner", 32'(owner), 32'(e.own));
                    check("sb_wdata", 32'(wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int gaps;
        int sum;
        w_rst    = 1'b1;
        req      = 4'b0000;
        full     = 1'b0;
        req_data = 32'd0;

        // 1: single requester, 1-cycle arbitration latency, 3 beats then drop
        apply_reset(4'b0100);
        tick();
        check("t1_idle_busy", 32'(s_busy), 32'd0);
        check("t1_idle_wen",  32'(s_wen),  32'd0);
        push_exp(2, 3);
        repeat (3) begin
            tick();
            check("t1_wen",   32'(s_wen),   32'd1);
            check("t1_gnt",   32'(s_gnt),   32'h4);
            check("t1_owner", 32'(s_owner), 32'd2);
        end
        req = 4'b0000;
        tick();
        check("t1_drop_wen", 32'(s_wen), 32'd0);
        tick();
        check("t1_back_idle", 32'(s_busy), 32'd0);
        check("t1_write_count", 32'(wr_cnt), 32'd3);
        end_test("t1_queue_drained");

        // 2: all requesting, 16-beat bursts rotating 0,1,2,3,0 with no bubble
        apply_reset(4'b1111);
        tick();
        for (int r = 0; r < 5; r++) push_exp(r % 4, 16);
        gaps = 0;
        repeat (80) begin
            tick();
            if (!s_wen) gaps++;
        end
        check("t2_no_bubble", 32'(gaps), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        check("t2_idle", 32'(s_busy), 32'd0);
        end_test("t2_queue_drained");

        // 3: full stall at beat 5 of owner 1, resume, rotate after 16 beats
        apply_reset(4'b0110);
        tick();
        push_exp(1, 16);
        push_exp(2, 1);
        repeat (5) tick();
        full = 1'b1;
        repeat (4) begin
            tick();
            check("t3_stall_wen",   32'(s_wen),   32'd0);
            check("t3_stall_gnt",   32'(s_gnt),   32'd0);
            check("t3_stall_owner", 32'(s_owner), 32'd1);
            check("t3_stall_busy",  32'(s_busy),  32'd1);
        end
        full = 1'b0;
        repeat (11) tick();
        tick();
        check("t3_rotated_owner", 32'(s_owner), 32'd2);
        check("t3_rotated_wen",   32'(s_wen),   32'd1);
        req = 4'b0000;
        tick();
        tick();
        end_test("t3_queue_drained");

        // 4: sole requester re-picked every 16 beats without a bubble
        apply_reset(4'b1000);
        tick();
        push_exp(3, 40);
        gaps = 0;
        repeat (40) begin
            tick();
            if (!s_wen) gaps++;
        end
        check("t4_no_bubble", 32'(gaps), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        end_test("t4_queue_drained");

        // 5: reset mid-burst drops w_en/gnt at once; restart from owner 0
        apply_reset(4'b0100);
        tick();
        push_exp(2, 7);
        repeat (7) tick();
        check("t5_pre_rst_wen", 32'(w_en), 32'd1);
        w_rst = 1'b1;
        #1;
        check("t5_rst_wen",  32'(w_en), 32'd0);
        check("t5_rst_gnt",  32'(gnt),  32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        req = 4'b0011;
        tick();
        w_rst = 1'b0;
        tick();
        check("t5_idle_wen", 32'(s_wen), 32'd0);
        push_exp(0, 3);
        repeat (3) begin
            tick();
            check("t5_owner0", 32'(s_owner), 32'd0);
        end
        req = 4'b0000;
        tick();
        tick();
        end_test("t5_queue_drained");

        // 6: random req/full; invariants, per-requester order, beats vs writes
        apply_reset(4'b0000);
        rand_mode = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            req  = 4'($urandom_range(0, 15));
            full = ($urandom_range(0, 3) == 0);
            tick();
        end
        req  = 4'b0000;
        full = 1'b0;
        tick();
        tick();
        rand_mode = 1'b0;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += prod_seq[i];
        check("t6_beats_eq_writes", 32'(sum), 32'(wr_cnt));
        check("t6_some_writes", 32'(wr_cnt > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
